// File: rtl/seg_reader_if.sv
// Handshake bundle between a seven-segment reader and its consumer.
// The reader sits on the slave side; the pattern source/consumer is the master.
interface seg_reader_if;
   logic [6:0] seg_in;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] out_nibble;
   logic       out_err;

   modport master (
      output seg_in,
      output out_ready,
      input  out_valid,
      input  out_nibble,
      input  out_err
   );

   modport slave (
      input  seg_in,
      input  out_ready,
      output out_valid,
      output out_nibble,
      output out_err
   );
endinterface

// File: rtl/seg_reader.sv
// Debounced seven-segment decoder: a stable active-low pattern is decoded to a
// hex nibble (or flagged as illegal) and offered once on a valid/ready port.
module seg_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   seg_reader_if.slave bus
);
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [7:0] LAST  = 8'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, WAIT_CHANGE} state_t;

   state_t     state, state_nxt;
   logic [6:0] s1, s2;
   logic [6:0] cap, cap_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [3:0] nib, nib_nxt;
   logic       err, err_nxt;
   logic [4:0] dec;

   // Returns {err, nibble}; anything outside the 16 legal codes is an error.
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'b1000000: return 5'h00;
         7'b1111001: return 5'h01;
         7'b0100100: return 5'h02;
         7'b0110000: return 5'h03;
         7'b0011001: return 5'h04;
         7'b0010010: return 5'h05;
         7'b0000010: return 5'h06;
         7'b1111000: return 5'h07;
         7'b0000000: return 5'h08;
         7'b0011000: return 5'h09;
         7'b0001000: return 5'h0a;
         7'b0000011: return 5'h0b;
         7'b0100111: return 5'h0c;
         7'b0100001: return 5'h0d;
         7'b0000110: return 5'h0e;
         7'b0001110: return 5'h0f;
         default:    return 5'h10;
      endcase
   endfunction

   assign dec = decode(cap);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, which is what makes s1 -> s2 a real two-stage chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= BLANK;
         s2 <= BLANK;
      end else begin
         s1 <= bus.seg_in;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cap   <= BLANK;
         cnt   <= 8'd0;
         nib   <= 4'd0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cap   <= cap_nxt;
         cnt   <= cnt_nxt;
         nib   <= nib_nxt;
         err   <= err_nxt;
      end
   end

   // NOTE: every output of this block gets a hold-value default first, so no
   // path through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cap_nxt   = cap;
      cnt_nxt   = cnt;
      nib_nxt   = nib;
      err_nxt   = err;
      case (state)
         IDLE: begin
            if (s2 != BLANK) begin
               state_nxt = SETTLE;
               cap_nxt   = s2;
               cnt_nxt   = 8'd1;
            end
         end
         SETTLE: begin
            if (s2 == BLANK) begin
               state_nxt = IDLE;
            end else if (s2 != cap) begin
               cap_nxt = s2;
               cnt_nxt = 8'd1;
            end else if (cnt == LAST) begin
               state_nxt = PRESENT;
               err_nxt   = dec[4];
               nib_nxt   = dec[3:0];
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         PRESENT: begin
            if (bus.out_ready) state_nxt = WAIT_CHANGE;
         end
         WAIT_CHANGE: begin
            // Holding the last reported pattern must not produce a repeat.
            if (s2 == BLANK) begin
               state_nxt = IDLE;
            end else if (s2 != cap) begin
               state_nxt = SETTLE;
               cap_nxt   = s2;
               cnt_nxt   = 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.out_valid  = (state == PRESENT);
   assign bus.out_nibble = nib;
   assign bus.out_err    = err;
endmodule

// File: tb/tb_seg_reader.sv
// Self-checking bench for seg_reader: code table plus hand-written sequences
// for latency, back-pressure, glitch rejection and reset.
`timescale 1ns/1ps
module tb_seg_reader;
   localparam int         STABLE = 4;
   localparam logic [6:0] BLANK  = 7'b1111111;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] nib;
      logic       err;
   } vec_t;

   typedef struct {
      logic [3:0] nib;
      logic       err;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   seg_reader_if bus ();

   seg_reader #(.STABLE_CYCLES(STABLE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   checks  = 0;
   int   errors  = 0;
   int   reports = 0;
   exp_t sb[$];
   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: a transfer happens at the next rising edge whenever
   // valid and ready are both high mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            reports++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got nibble %0h err %0b, expected no report",
                        bus.out_nibble, bus.out_err);
            end else begin
               e = sb.pop_front();
               check("sb_nibble", 32'(bus.out_nibble), 32'(e.nib));
               check("sb_err", 32'(bus.out_err), 32'(e.err));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_report(input int prev, input string name);
      int n = 0;
      while (reports == prev && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(name, 32'(reports != prev), 32'd1);
   endtask

   initial begin
      int prev;
      int vc;
      int n;

      vecs[0]  = '{7'b1000000, 4'h0, 1'b0};
      vecs[1]  = '{7'b1111001, 4'h1, 1'b0};
      vecs[2]  = '{7'b0100100, 4'h2, 1'b0};
      vecs[3]  = '{7'b0110000, 4'h3, 1'b0};
      vecs[4]  = '{7'b0011001, 4'h4, 1'b0};
      vecs[5]  = '{7'b0010010, 4'h5, 1'b0};
      vecs[6]  = '{7'b0000010, 4'h6, 1'b0};
      vecs[7]  = '{7'b1111000, 4'h7, 1'b0};
      vecs[8]  = '{7'b0000000, 4'h8, 1'b0};
      vecs[9]  = '{7'b0011000, 4'h9, 1'b0};
      vecs[10] = '{7'b0001000, 4'hA, 1'b0};
      vecs[11] = '{7'b0000011, 4'hB, 1'b0};
      vecs[12] = '{7'b0100111, 4'hC, 1'b0};
      vecs[13] = '{7'b0100001, 4'hD, 1'b0};
      vecs[14] = '{7'b0000110, 4'hE, 1'b0};
      vecs[15] = '{7'b0001110, 4'hF, 1'b0};
      vecs[16] = '{7'b1010101, 4'h0, 1'b1};

      bus.seg_in    = BLANK;
      bus.out_ready = 1'b0;

      // Reset takes effect before the first clock edge.
      #1 reset = 1'b1;
      #1;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_nibble", 32'(bus.out_nibble), 32'd0);
      check("rst_err", 32'(bus.out_err), 32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) step();

      // Code 2 held with ready high: valid after edge 6 for one cycle only.
      bus.out_ready = 1'b1;
      sb.push_back('{4'h2, 1'b0});
      bus.seg_in = 7'b0100100;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("lat_edge%0d", k), 32'(bus.out_valid), 32'(k == 6));
      end
      check("retain_nibble", 32'(bus.out_nibble), 32'h2);
      prev = reports;
      repeat (15) @(negedge clk);
      check("no_repeat", 32'(reports), 32'(prev));

      // Code E under back-pressure, then 1 reported 6 edges after transfer.
      step();
      bus.seg_in    = BLANK;
      bus.out_ready = 1'b0;
      repeat (4) step();
      sb.push_back('{4'hE, 1'b0});
      bus.seg_in = 7'b0000110;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("e_valid", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 12; i++) begin
         step();
         bus.seg_in = (i >= 4 && i < 8) ? 7'b0110000 : 7'b0000110;
         @(negedge clk);
         check($sformatf("hold_valid%0d", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("hold_nibble%0d", i), 32'(bus.out_nibble), 32'hE);
      end
      step();
      sb.push_back('{4'h1, 1'b0});
      bus.out_ready = 1'b1;
      bus.seg_in    = 7'b1111001;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("after_xfer_edge%0d", k), 32'(bus.out_valid), 32'(k == 6));
      end

      // Full code sweep, each separated by blank; illegal pattern last.
      for (int i = 0; i < 17; i++) begin
         step();
         bus.seg_in = BLANK;
         repeat (3) step();
         prev = reports;
         sb.push_back('{vecs[i].nib, vecs[i].err});
         bus.seg_in = vecs[i].seg;
         wait_report(prev, $sformatf("code%0d_reported", i));
      end

      // Pattern/blank alternating every 3 cycles never settles.
      step();
      bus.seg_in = BLANK;
      repeat (4) step();
      prev = reports;
      vc = 0;
      for (int i = 0; i < 12; i++) begin
         bus.seg_in = (i % 2 == 0) ? 7'b0110000 : BLANK;
         repeat (3) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) vc++;
            @(posedge clk);
            #1;
         end
      end
      check("glitch_no_valid", 32'(vc), 32'd0);
      check("glitch_no_report", 32'(reports), 32'(prev));

      // Reset in mid-SETTLE discards the pending 4; full latency after release.
      bus.seg_in = BLANK;
      repeat (4) step();
      check("retain_err", 32'(bus.out_err), 32'd1);
      bus.seg_in = 7'b0011001;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("pre_rst_edge%0d", k), 32'(bus.out_valid), 32'd0);
      end
      reset = 1'b1;
      #1;
      check("async_valid", 32'(bus.out_valid), 32'd0);
      check("async_nibble", 32'(bus.out_nibble), 32'd0);
      check("async_err", 32'(bus.out_err), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      sb.push_back('{4'h4, 1'b0});
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("post_rst_edge%0d", k), 32'(bus.out_valid), 32'(k == 6));
      end
      repeat (4) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive synchronized samples that must match before a pattern is reported (legal range 2..255).
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 seg_in  input  7  active-low segment pattern, bit6=g .. bit0=a, asynchronous to clk.
REQ-005 out_ready  input  1  consumer accepts the current result.
REQ-006 out_valid  output  1  a result is presented on out_nibble/out_err.
REQ-007 out_nibble  output  4  decoded hex value (0 when out_err=1).
REQ-008 out_err  output  1  stable pattern is neither blank nor one of the 16 legal codes.

Function
REQ-009 seg_in SHALL pass through a two-flop synchronizer (s1, s2); only s2 is used by the rest of the block.
REQ-010 Legal codes (s2 -> nibble) SHALL be: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9, 0001000->A, 0000011->B, 0100111->C, 0100001->D, 0000110->E, 0001110->F.
REQ-011 Pattern 1111111 (blank) SHALL be treated as idle and never reported.
REQ-012 Any other stable non-blank pattern SHALL be reported with out_err=1, out_nibble=0.
REQ-013 FSM states SHALL be IDLE, SETTLE, PRESENT, WAIT_CHANGE; 8-bit counter cnt; 7-bit capture register cap.
REQ-014 IDLE: s2 blank -> stay; s2 non-blank -> SETTLE, cap=s2, cnt=1.
REQ-015 SETTLE: s2 blank -> IDLE; s2!=cap -> stay, cap=s2, cnt=1; s2==cap and cnt==STABLE_CYCLES-1 -> PRESENT, load out_nibble/out_err from cap; else cnt=cnt+1.
REQ-016 PRESENT: out_valid=1; out_nibble/out_err SHALL hold constant regardless of seg_in until transfer.
REQ-017 Transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1; next state WAIT_CHANGE, out_valid=0 the following cycle.
REQ-018 out_ready SHALL be ignored in every state other than PRESENT; out_valid SHALL NOT depend combinationally on out_ready.
REQ-019 WAIT_CHANGE: s2==cap -> stay (same pattern is never reported twice); s2 blank -> IDLE; other s2 -> SETTLE, cap=s2, cnt=1.
REQ-020 Latency: a pattern applied before edge 1 and held SHALL raise out_valid after edge STABLE_CYCLES+2 (edge 6 at default).
REQ-021 A glitch of any length shorter than STABLE_CYCLES samples SHALL restart the count and SHALL NOT produce a report.
REQ-022 out_nibble/out_err SHALL retain their last presented value outside PRESENT.

Reset
REQ-023 While reset=1: state=IDLE, s1=s2=cap=1111111, cnt=0, out_valid=0, out_nibble=0, out_err=0, effective immediately without a clock edge.
REQ-024 Reset asserted mid-SETTLE or mid-PRESENT SHALL discard the pending result; after release the block restarts from IDLE and requires a full STABLE_CYCLES+2 edges to report.

Verification
REQ-025 seg_in=0100100 held, out_ready=1 -> out_valid=1 after edge 6 for one cycle, out_nibble=2, out_err=0; no second report while held.
REQ-026 seg_in=0000110 held, out_ready=0 for 10 cycles, then seg_in->1111001, then out_ready=1 -> out_valid held 10+ cycles with out_nibble=E; after transfer, 1 reported 6 edges later.
REQ-027 seg_in=1010101 held -> out_valid=1, out_err=1, out_nibble=0.
REQ-028 seg_in toggles 0110000/blank every 3 cycles -> out_valid never asserts.
REQ-029 seg_in=0011001 held, reset pulsed at edge 5 for 1 cycle -> no report before reset; out_valid=1, nibble=4, 6 edges after release; async clear checked between edges.
REQ-030 Sweep all 16 legal codes, each separated by blank, out_ready=1 -> out_nibble sequence 0..F, out_err=0 throughout.
